// File: rtl/fifo_arb_ctrl_if.sv
// Bus bundle for fifo_arb_ctrl: requester ports, consumer read port and the strobe-driven FIFO port.
// Parameters must match the fifo_arb_ctrl instance that uses it.
interface fifo_arb_ctrl_if #(
    parameter int DATO_WIDTH = 3,
    parameter int NUM_REQ    = 3
);
    // Handshakes: a requester raises req[i] with req_dat slice i and holds both until gnt[i]
    // pulses for one cycle (that pulse is the completed transfer). rd_req is a level; every
    // accepted read is reported by a one-cycle rd_valid with rd_dat already updated.
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATO_WIDTH-1:0] req_dat;
    logic [NUM_REQ-1:0]            gnt;
    logic                          rd_req;
    logic [DATO_WIDTH-1:0]         rd_dat;
    logic                          rd_valid;
    logic                          fifo_wclk;
    logic                          fifo_rclk;
    logic                          fifo_rst;
    logic [DATO_WIDTH-1:0]         fifo_datin;
    logic [DATO_WIDTH-1:0]         fifo_datout;
    logic                          fifo_full;
    logic                          fifo_empy;

    modport master (
        input  req, req_dat, rd_req, fifo_datout, fifo_full, fifo_empy,
        output gnt, rd_dat, rd_valid, fifo_wclk, fifo_rclk, fifo_rst, fifo_datin
    );

    modport slave (
        output req, req_dat, rd_req, fifo_datout, fifo_full, fifo_empy,
        input  gnt, rd_dat, rd_valid, fifo_wclk, fifo_rclk, fifo_rst, fifo_datin
    );
endinterface

// File: rtl/fifo_arb_ctrl.sv
// Arbitrates NUM_REQ writers into an external strobe-clocked FIFO and paces reads from it.
// Define FIFO_ARB_FIXED_PRIO_EN to replace round-robin with fixed (lowest index) priority.
module fifo_arb_ctrl #(
    parameter int DATO_WIDTH = 3,
    parameter int NUM_REQ    = 3
) (
    input  logic            clk,
    input  logic            rst,
    fifo_arb_ctrl_if.master bus,
    output logic [1:0]      dbg_w_state,
    output logic [1:0]      dbg_r_state
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] { W_IDLE = 2'd0, W_PULSE = 2'd1, W_GAP = 2'd2 } w_state_t;
    typedef enum logic [1:0] { R_IDLE = 2'd0, R_PULSE = 2'd1, R_CAP = 2'd2 } r_state_t;

    w_state_t      w_state, w_next;
    r_state_t      r_state, r_next;
    logic [IW-1:0] win_idx;
    logic [IW-1:0] pick;
    logic          pick_ok;
    logic          w_start;

`ifdef FIFO_ARB_FIXED_PRIO_EN
    always_comb begin
        pick    = '0;
        pick_ok = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                pick    = IW'(i);
                pick_ok = 1'b1;
            end
        end
    end
`else
    logic [IW-1:0] last_winner;
    logic [IW-1:0] idx;

    // Walk downward so the candidate closest to last_winner+1 is assigned last and wins.
    always_comb begin
        pick    = '0;
        pick_ok = 1'b0;
        idx     = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = IW'((int'(last_winner) + k) % NUM_REQ);
            if (bus.req[idx]) begin
                pick    = idx;
                pick_ok = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)         last_winner <= IW'(NUM_REQ - 1);
        else if (w_start) last_winner <= pick;
    end
`endif

    assign w_start = (w_state == W_IDLE) && pick_ok && !bus.fifo_full;

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (w_start) w_next = W_PULSE;
            W_PULSE: w_next = W_GAP;
            W_GAP:   w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (bus.rd_req && !bus.fifo_empy) r_next = R_PULSE;
            R_PULSE: r_next = R_CAP;
            R_CAP:   r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    // Outputs follow the state one edge later, so strobes and grants are clean register outputs.
    always_ff @(posedge clk) begin
        bus.fifo_rst <= ~rst;
        if (!rst) begin
            win_idx        <= '0;
            bus.fifo_datin <= '0;
            bus.fifo_wclk  <= 1'b0;
            bus.gnt        <= '0;
        end else begin
            if (w_start) begin
                win_idx        <= pick;
                bus.fifo_datin <= bus.req_dat[int'(pick)*DATO_WIDTH +: DATO_WIDTH];
            end
            bus.fifo_wclk <= (w_state == W_PULSE);
            bus.gnt       <= (w_state == W_PULSE) ? (NUM_REQ'(1) << win_idx) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.fifo_rclk <= 1'b0;
            bus.rd_valid  <= 1'b0;
            bus.rd_dat    <= '0;
        end else begin
            bus.fifo_rclk <= (r_state == R_PULSE);
            bus.rd_valid  <= (r_state == R_CAP);
            if (r_state == R_CAP) bus.rd_dat <= bus.fifo_datout;
        end
    end

    assign dbg_w_state = w_state;
    assign dbg_r_state = r_state;
endmodule

// File: tb/tb_fifo_arb_ctrl.sv
// Bench for fifo_arb_ctrl: directed scenarios plus randomized traffic against a cycle-level
// reference of the arbitration and pacing rules, with a behavioural 5-deep FIFO on the strobes.
module tb_fifo_arb_ctrl;
    localparam int W     = 3;
    localparam int N     = 3;
    localparam int DEPTH = 5;
    localparam int MAXC  = 1200;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] dbg_w_state;
    logic [1:0] dbg_r_state;
    int         total = 0;
    int         bad   = 0;

    fifo_arb_ctrl_if #(.DATO_WIDTH(W), .NUM_REQ(N)) bus ();

    fifo_arb_ctrl #(.DATO_WIDTH(W), .NUM_REQ(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_w_state (dbg_w_state),
        .dbg_r_state (dbg_r_state)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural FIFO driven by the strobes ----------------
    logic [W-1:0] fq[$];
    logic         prev_wclk = 1'b0;
    logic         prev_rclk = 1'b0;
    int           push_cnt  = 0;
    int           ovf       = 0;
    int           unf       = 0;

    task automatic fifo_flags();
        bus.fifo_full = (fq.size() >= DEPTH);
        bus.fifo_empy = (fq.size() == 0);
    endtask

    always @(posedge clk) begin
        #1;
        if (bus.fifo_rst === 1'b1) begin
            fq.delete();
        end else begin
            if (bus.fifo_rclk === 1'b1 && !prev_rclk) begin
                if (fq.size() == 0) unf++;
                else bus.fifo_datout = fq.pop_front();
            end
            if (bus.fifo_wclk === 1'b1 && !prev_wclk) begin
                push_cnt++;
                if (fq.size() >= DEPTH) ovf++;
                else fq.push_back(bus.fifo_datin);
            end
        end
        prev_wclk = (bus.fifo_wclk === 1'b1);
        prev_rclk = (bus.fifo_rclk === 1'b1);
        fifo_flags();
    end

    // ---------------- reference arbitration rule ----------------
    function automatic int ref_pick(input logic [N-1:0] r, input int last);
`ifdef FIFO_ARB_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (r[i]) return i;
        if (last < 0) return -1;
`else
        for (int k = 1; k <= N; k++) if (r[(last + k) % N]) return (last + k) % N;
`endif
        return -1;
    endfunction

    task automatic apply_reset(input int n);
        rst         = 1'b0;
        bus.req     = '0;
        bus.req_dat = '0;
        bus.rd_req  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        apply_reset(3);
        total++; if (bus.gnt !== '0)        begin bad++; $display("FAIL reset_gnt: got %b want 000", bus.gnt); end
        total++; if (bus.fifo_wclk !== 1'b0) begin bad++; $display("FAIL reset_wclk: got %b want 0", bus.fifo_wclk); end
        total++; if (bus.fifo_rclk !== 1'b0) begin bad++; $display("FAIL reset_rclk: got %b want 0", bus.fifo_rclk); end
        total++; if (bus.rd_valid !== 1'b0)  begin bad++; $display("FAIL reset_rd_valid: got %b want 0", bus.rd_valid); end
        total++; if (bus.rd_dat !== '0)      begin bad++; $display("FAIL reset_rd_dat: got %0d want 0", bus.rd_dat); end
        total++; if (bus.fifo_datin !== '0)  begin bad++; $display("FAIL reset_datin: got %0d want 0", bus.fifo_datin); end
        total++; if (bus.fifo_rst !== 1'b1)  begin bad++; $display("FAIL reset_fifo_rst: got %b want 1", bus.fifo_rst); end
        rst = 1'b1;
        @(negedge clk);
        total++; if (bus.fifo_rst !== 1'b0)  begin bad++; $display("FAIL release_fifo_rst: got %b want 0", bus.fifo_rst); end
    endtask

    task automatic test_rr_order();
        logic [N-1:0] e;
        apply_reset(2);
        bus.req_dat = {3'd3, 3'd2, 3'd1};
        bus.req     = 3'b111;
        rst         = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            e = (c == 2) ? 3'b001 : (c == 5) ? 3'b010 : (c == 8) ? 3'b100 : 3'b000;
            total++; if (bus.gnt !== e) begin bad++; $display("FAIL rr_gnt c=%0d: got %b want %b", c, bus.gnt, e); end
            total++; if (bus.fifo_wclk !== (e != 0)) begin bad++; $display("FAIL rr_wclk c=%0d: got %b want %b", c, bus.fifo_wclk, e != 0); end
            bus.req = bus.req & ~bus.gnt;
        end
        total++; if (fq.size() != 3) begin bad++; $display("FAIL rr_fifo_count: got %0d want 3", fq.size()); end
        for (int i = 0; i < 3 && i < fq.size(); i++) begin
            total++; if (fq[i] !== W'(i + 1)) begin bad++; $display("FAIL rr_fifo_word%0d: got %0d want %0d", i, fq[i], i + 1); end
        end
    endtask

    task automatic test_full_block();
        int waited;
        int nv;
        bit got;
        waited = 0; nv = 0; got = 0;
        apply_reset(2);
        rst = 1'b1;
        @(negedge clk);
        fq.delete();
        fq.push_back(3'd7); fq.push_back(3'd1); fq.push_back(3'd2); fq.push_back(3'd3); fq.push_back(3'd4);
        fifo_flags();
        bus.req_dat = {3'd0, 3'd6, 3'd0};
        bus.req     = 3'b010;
        repeat (6) begin
            @(negedge clk);
            total++; if (bus.gnt !== '0) begin bad++; $display("FAIL full_block_gnt: got %b want 000", bus.gnt); end
        end
        bus.rd_req = 1'b1;
        @(negedge clk);
        bus.rd_req = 1'b0;
        while (bus.fifo_full && waited < 10) begin
            total++; if (bus.gnt !== '0) begin bad++; $display("FAIL full_wait_gnt: got %b want 000", bus.gnt); end
            @(negedge clk);
            waited++;
        end
        total++; if (bus.fifo_full !== 1'b0) begin bad++; $display("FAIL full_release: got full=%b want 0 within 10 cycles", bus.fifo_full); end
        repeat (2) begin
            @(negedge clk);
            if (bus.gnt === 3'b010) got = 1;
            if (bus.gnt[1]) bus.req = '0;
            if (bus.rd_valid === 1'b1) begin
                nv++;
                total++; if (bus.rd_dat !== 3'd7) begin bad++; $display("FAIL full_rd_dat: got %0d want 7", bus.rd_dat); end
            end
        end
        total++; if (!got) begin bad++; $display("FAIL full_late_gnt: got none want 010 within 2 cycles"); end
        total++; if (nv != 1) begin bad++; $display("FAIL full_rd_valid_count: got %0d want 1", nv); end
        total++; if (fq.size() != 5 || fq[4] !== 3'd6) begin bad++; $display("FAIL full_fifo_tail: got size=%0d tail=%0d want 5/6", fq.size(), fq[fq.size()-1]); end
        bus.req = '0;
    endtask

    task automatic test_read();
        int   nv;
        int   nr;
        logic pr;
        nv = 0; nr = 0; pr = 1'b0;
        apply_reset(2);
        rst = 1'b1;
        @(negedge clk);
        fq.delete(); fq.push_back(3'd4); fq.push_back(3'd5);
        fifo_flags();
        bus.rd_req = 1'b1;
        repeat (15) begin
            @(negedge clk);
            if (bus.rd_valid === 1'b1) begin
                total++; if (bus.rd_dat !== ((nv == 0) ? 3'd4 : 3'd5)) begin bad++; $display("FAIL read_dat%0d: got %0d want %0d", nv, bus.rd_dat, (nv == 0) ? 4 : 5); end
                nv++;
            end
            if (bus.fifo_rclk === 1'b1 && !pr) nr++;
            pr = (bus.fifo_rclk === 1'b1);
        end
        bus.rd_req = 1'b0;
        total++; if (nv != 2) begin bad++; $display("FAIL read_valid_count: got %0d want 2", nv); end
        total++; if (nr != 2) begin bad++; $display("FAIL read_rclk_count: got %0d want 2", nr); end
        total++; if (unf != 0) begin bad++; $display("FAIL read_underflow: got %0d want 0", unf); end
    endtask

    task automatic test_simul();
        apply_reset(2);
        rst = 1'b1;
        @(negedge clk);
        fq.delete(); fq.push_back(3'd2);
        fifo_flags();
        bus.req_dat = {3'd0, 3'd0, 3'd6};
        bus.req     = 3'b001;
        bus.rd_req  = 1'b1;
        @(negedge clk);
        bus.rd_req = 1'b0;
        @(negedge clk);
        total++; if (bus.fifo_wclk !== 1'b1) begin bad++; $display("FAIL simul_wclk: got %b want 1", bus.fifo_wclk); end
        total++; if (bus.fifo_rclk !== 1'b1) begin bad++; $display("FAIL simul_rclk: got %b want 1", bus.fifo_rclk); end
        total++; if (bus.gnt !== 3'b001)     begin bad++; $display("FAIL simul_gnt: got %b want 001", bus.gnt); end
        bus.req = bus.req & ~bus.gnt;
        total++; if (fq.size() != 1) begin bad++; $display("FAIL simul_count: got %0d want 1", fq.size()); end
        @(negedge clk);
        total++; if (bus.rd_valid !== 1'b1 || bus.rd_dat !== 3'd2) begin bad++; $display("FAIL simul_rd: got v=%b d=%0d want 1/2", bus.rd_valid, bus.rd_dat); end
        total++; if (fq[0] !== 3'd6) begin bad++; $display("FAIL simul_remaining: got %0d want 6", fq[0]); end
    endtask

    task automatic test_abort();
        int pc;
        logic [N-1:0] e;
        apply_reset(2);
        bus.req_dat = {3'd0, 3'd0, 3'd5};
        bus.req     = 3'b001;
        rst         = 1'b1;
        @(negedge clk);
        pc  = push_cnt;
        rst = 1'b0;
        @(negedge clk);
        total++; if (bus.gnt !== '0)         begin bad++; $display("FAIL abort_gnt: got %b want 000", bus.gnt); end
        total++; if (bus.fifo_wclk !== 1'b0) begin bad++; $display("FAIL abort_wclk: got %b want 0", bus.fifo_wclk); end
        total++; if (bus.fifo_rst !== 1'b1)  begin bad++; $display("FAIL abort_fifo_rst: got %b want 1", bus.fifo_rst); end
        @(negedge clk);
        total++; if (bus.gnt !== '0 || push_cnt != pc) begin bad++; $display("FAIL abort_no_write: got gnt=%b pushes=%0d want 000/%0d", bus.gnt, push_cnt, pc); end
        bus.req_dat = {3'd3, 3'd2, 3'd0};
        bus.req     = 3'b110;
        rst         = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            e = (c == 2) ? 3'b010 : 3'b000;
            total++; if (bus.gnt !== e) begin bad++; $display("FAIL abort_regrant c=%0d: got %b want %b", c, bus.gnt, e); end
            bus.req = bus.req & ~bus.gnt;
        end
    endtask

    task automatic test_hold();
        logic [N-1:0] e;
        apply_reset(2);
        bus.req_dat = {3'd0, 3'd2, 3'd1};
        bus.req     = 3'b011;
        rst         = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            e = 3'b000;
`ifdef FIFO_ARB_FIXED_PRIO_EN
            if (c % 3 == 2) e = 3'b001;
`else
            if (c % 3 == 2) e = ((c / 3) % 2 == 0) ? 3'b001 : 3'b010;
`endif
            total++; if (bus.gnt !== e) begin bad++; $display("FAIL hold_gnt c=%0d: got %b want %b", c, bus.gnt, e); end
        end
        bus.req = '0;
    endtask

    logic [N-1:0] eg [0:MAXC+3];
    logic         er [0:MAXC+3];
    logic         ev [0:MAXC+3];

    task automatic test_random();
        logic [W-1:0] exp_q[$];
        int  last_w, w_since, r_since, win, quiet, grants;
        bit  draining;
        last_w = N - 1; w_since = 3; r_since = 3; quiet = 0; grants = 0; draining = 0;
        for (int i = 0; i <= MAXC + 3; i++) begin eg[i] = '0; er[i] = 1'b0; ev[i] = 1'b0; end
        apply_reset(2);
        rst = 1'b1;
        for (int cyc = 0; cyc < MAXC; cyc++) begin
            if (w_since >= 3 && bus.req != '0 && !bus.fifo_full) begin
                win = ref_pick(bus.req, last_w);
                eg[cyc+2] = N'(1) << win;
                exp_q.push_back(bus.req_dat[win*W +: W]);
                last_w = win; w_since = 1; grants++;
            end else if (w_since < 3) w_since++;
            if (r_since >= 3 && bus.rd_req && !bus.fifo_empy) begin
                er[cyc+2] = 1'b1; ev[cyc+3] = 1'b1; r_since = 1;
            end else if (r_since < 3) r_since++;

            @(negedge clk);
            total++; if (bus.gnt !== eg[cyc+1]) begin bad++; $display("FAIL rand_gnt cyc=%0d: got %b want %b", cyc + 1, bus.gnt, eg[cyc+1]); end
            total++; if (bus.fifo_wclk !== (eg[cyc+1] != '0)) begin bad++; $display("FAIL rand_wclk cyc=%0d: got %b want %b", cyc + 1, bus.fifo_wclk, eg[cyc+1] != '0); end
            total++; if (bus.fifo_rclk !== er[cyc+1]) begin bad++; $display("FAIL rand_rclk cyc=%0d: got %b want %b", cyc + 1, bus.fifo_rclk, er[cyc+1]); end
            total++; if (bus.rd_valid !== ev[cyc+1]) begin bad++; $display("FAIL rand_rd_valid cyc=%0d: got %b want %b", cyc + 1, bus.rd_valid, ev[cyc+1]); end
            if (bus.rd_valid === 1'b1 && exp_q.size() > 0) begin
                logic [W-1:0] want;
                want = exp_q.pop_front();
                total++; if (bus.rd_dat !== want) begin bad++; $display("FAIL rand_rd_dat cyc=%0d: got %0d want %0d", cyc + 1, bus.rd_dat, want); end
            end

            for (int i = 0; i < N; i++) if (bus.gnt[i] === 1'b1) bus.req[i] = 1'b0;
            if (!draining) begin
                for (int i = 0; i < N; i++) begin
                    if (!bus.req[i] && $urandom_range(0, 3) == 0) begin
                        bus.req[i] = 1'b1;
                        bus.req_dat[i*W +: W] = W'($urandom_range(0, (1 << W) - 1));
                    end
                end
            end
            bus.rd_req = draining ? 1'b1 : ($urandom_range(0, 2) != 0);
            if (cyc >= 600) draining = 1;
            quiet = (draining && exp_q.size() == 0 && bus.req == '0) ? quiet + 1 : 0;
            if (quiet >= 4) break;
        end
        bus.rd_req = 1'b0;
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rand_drain: got %0d words left want 0", exp_q.size()); end
        total++; if (ovf != 0 || unf != 0) begin bad++; $display("FAIL rand_fifo_abuse: got ovf=%0d unf=%0d want 0/0", ovf, unf); end
        total++; if (grants < 20) begin bad++; $display("FAIL rand_activity: got %0d grants want >= 20", grants); end
    endtask

    initial begin
        bus.req         = '0;
        bus.req_dat     = '0;
        bus.rd_req      = 1'b0;
        bus.fifo_datout = '0;
        bus.fifo_full   = 1'b0;
        bus.fifo_empy   = 1'b1;
        test_reset();
        test_rr_order();
        test_full_block();
        test_read();
        test_simul();
        test_abort();
        test_hold();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
